// File: rtl/full_adder_structural_verilog_if.sv
// Operand/result bundle for the registered structural adder.
// Ports: X1/X2 addends, Cin carry in (master -> slave); S sum, Cout carry out (slave -> master).
interface full_adder_structural_verilog_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] X1;
    logic [WIDTH-1:0] X2;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output X1,
        output X2,
        output Cin,
        input  S,
        input  Cout
    );

    modport slave (
        input  X1,
        input  X2,
        input  Cin,
        output S,
        output Cout
    );
endinterface

// File: rtl/full_adder_structural_verilog.sv
// Gate-level ripple-carry adder with registered sum and carry out.
// Ports: clk, rst (sync, active-high); bus.X1/X2/Cin in, bus.S/Cout out, 1-cycle latency.

// XOR/AND half adder built from gate primitives.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    xor g_x (s, a, b);
    and g_a (c, a, b);
endmodule

// One full-adder cell: two half adders, carries merged by an OR.
// The first half adder's sum is the propagate term p = a ^ b.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g;
    logic pc;

    half_adder ha0 (
        .a (a),
        .b (b),
        .s (p),
        .c (g)
    );

    half_adder ha1 (
        .a (p),
        .b (ci),
        .s (s),
        .c (pc)
    );

    or g_o (co, g, pc);
endmodule

module full_adder_structural_verilog #(
    parameter int WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    full_adder_structural_verilog_if.slave bus
);
    // c[0] is the external carry in; c[WIDTH] leaves the top cell.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (bus.X1[i]),
            .b  (bus.X2[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.S    <= '0;
            bus.Cout <= 1'b0;
        end else begin
            bus.S    <= s;
            bus.Cout <= c[WIDTH];
        end
    end
endmodule

// File: tb/tb_full_adder_structural_verilog.sv
// Bench for the registered structural adder at WIDTH=1 and WIDTH=4.
// Both instances run in lockstep against an arithmetic reference.
module tb_full_adder_structural_verilog;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    full_adder_structural_verilog_if #(.WIDTH(1)) b1 ();
    full_adder_structural_verilog_if #(.WIDTH(4)) b4 ();

    full_adder_structural_verilog #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    full_adder_structural_verilog #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    logic [4:0] sb4 [$];
    logic [1:0] sb1 [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref1(int a, int b, int ci, logic r);
        int t;
        t = a + b + ci;
        return r ? 2'd0 : 2'(t % 4);
    endfunction

    function automatic logic [4:0] ref4(int a, int b, int ci, logic r);
        int t;
        t = a + b + ci;
        return r ? 5'd0 : 5'(t % 32);
    endfunction

    task automatic drive1(int a, int b, int ci);
        b1.X1  = 1'(a);
        b1.X2  = 1'(b);
        b1.Cin = 1'(ci);
    endtask

    task automatic drive4(int a, int b, int ci);
        b4.X1  = 4'(a);
        b4.X2  = 4'(b);
        b4.Cin = 1'(ci);
    endtask

    initial begin
        logic [1:0] exp1;
        logic [4:0] exp4;
        logic [1:0] hold;
        logic [1:0] tbl [8];

        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        drive1(1, 1, 1);
        drive4(15, 15, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_w1", {b1.Cout, b1.S}, 0);
            check("rst_w4", {b4.Cout, b4.S}, 0);
        end

        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            drive1((v >> 2) & 1, (v >> 1) & 1, v & 1);
            tick();
            check("exh_w1", {b1.Cout, b1.S}, tbl[v]);
            check("exh_ref", {b1.Cout, b1.S},
                  ref1((v >> 2) & 1, (v >> 1) & 1, v & 1, 1'b0));
        end

        drive1(1, 0, 1);
        tick();
        hold = {b1.Cout, b1.S};
        check("hold_first", hold, 2'b10);
        for (int k = 0; k < 5; k++) begin
            #2;
            drive1(0, 0, 0);
            #1;
            check("glitch", {b1.Cout, b1.S}, hold);
            drive1(1, 0, 1);
            tick();
            check("hold", {b1.Cout, b1.S}, hold);
        end

        drive1(1, 1, 1);
        tick();
        check("pre_rst", {b1.Cout, b1.S}, 2'b11);
        rst = 1'b1;
        tick();
        check("mid_rst", {b1.Cout, b1.S}, 2'b00);
        rst = 1'b0;
        drive1(0, 1, 0);
        tick();
        check("post_rst", {b1.Cout, b1.S}, 2'b01);

        drive4(4'hF, 4'h0, 1);
        tick();
        check("rip_a", {b4.Cout, b4.S}, 5'h10);
        drive4(4'h7, 4'h8, 0);
        tick();
        check("rip_b", {b4.Cout, b4.S}, 5'h0F);

        for (int n = 0; n < 200; n++) begin
            int a4, c4, d4, a1, c1, d1;
            logic r;
            a4 = int'($urandom_range(15));
            c4 = int'($urandom_range(15));
            d4 = int'($urandom_range(1));
            a1 = int'($urandom_range(1));
            c1 = int'($urandom_range(1));
            d1 = int'($urandom_range(1));
            r  = ($urandom_range(19) == 0);
            rst = r;
            drive4(a4, c4, d4);
            drive1(a1, c1, d1);
            sb4.push_back(ref4(a4, c4, d4, r));
            sb1.push_back(ref1(a1, c1, d1, r));
            tick();
            exp4 = sb4.pop_front();
            exp1 = sb1.pop_front();
            check("rand_w4", {b4.Cout, b4.S}, exp4);
            check("rand_w1", {b1.Cout, b1.S}, exp1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
